// File: rtl/sseg_scan_controller.sv
// Four-digit seven-segment scan controller.
// Drives the active-low anodes and cathodes one digit at a time.
// Settings are double-buffered: a load lands in a pending buffer and
// reaches the active (shadow) copy only at a frame boundary, so a frame
// never mixes old and new values.
module sseg_scan_controller #(
    parameter int SLOT_BITS   = 17,
    parameter int DEAD_CYCLES = 16
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        ctrl_enable,
    input  logic        cfg_load,
    input  logic [15:0] cfg_digits,
    input  logic [3:0]  cfg_dp,
    input  logic [3:0]  cfg_blank,
    input  logic [3:0]  cfg_bright,
    output logic        cfg_pending,
    output logic        frame_done,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    logic [SLOT_BITS-1:0] cnt;
    logic [1:0]           d;

    logic [15:0] pend_digits;
    logic [3:0]  pend_dp;
    logic [3:0]  pend_blank;
    logic [3:0]  pend_bright;

    logic [15:0] sh_digits;
    logic [3:0]  sh_dp;
    logic [3:0]  sh_blank;
    logic [3:0]  sh_bright;

    logic       wrap;
    logic       lit;
    logic [3:0] level;
    logic [3:0] nibble;
    logic [3:0] an_next;
    logic [6:0] seg_next;

    // Frame boundary detect and anode-enable decision for the current slot position
    always_comb begin
        wrap    = ctrl_enable && (&cnt) && (d == 2'd3);
        level   = cnt[SLOT_BITS-1 -: 4];
        nibble  = sh_digits[{d, 2'b00} +: 4];
        lit     = ctrl_enable && !sh_blank[d]
                  && (cnt >= SLOT_BITS'(DEAD_CYCLES))
                  && (level <= sh_bright);
        an_next = 4'b1111;
        if (lit) begin
            an_next[d] = 1'b0;
        end
    end

    // Hex to active-low segment pattern, g in the MSB
    always_comb begin
        seg_next = 7'b1111111;
        case (nibble)
            4'h0: seg_next = 7'b1000000;
            4'h1: seg_next = 7'b1111001;
            4'h2: seg_next = 7'b0100100;
            4'h3: seg_next = 7'b0110000;
            4'h4: seg_next = 7'b0011001;
            4'h5: seg_next = 7'b0010010;
            4'h6: seg_next = 7'b0000010;
            4'h7: seg_next = 7'b1111000;
            4'h8: seg_next = 7'b0000000;
            4'h9: seg_next = 7'b0010000;
            4'hA: seg_next = 7'b0001000;
            4'hB: seg_next = 7'b0000011;
            4'hC: seg_next = 7'b1000110;
            4'hD: seg_next = 7'b0100001;
            4'hE: seg_next = 7'b0000110;
            default: seg_next = 7'b0001110;
        endcase
    end

    // Slot counter and digit index; both parked at zero while disabled
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt <= '0;
            d   <= '0;
        end else if (!ctrl_enable) begin
            cnt <= '0;
            d   <= '0;
        end else begin
            cnt <= cnt + SLOT_BITS'(1);
            if (&cnt) begin
                d <= d + 2'd1;
            end
        end
    end

    // Pending buffer and shadow update: a load that cannot tear a frame
    // (disabled, or landing on the boundary itself) bypasses the buffer
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_blank  <= '0;
            pend_bright <= '0;
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_blank    <= '0;
            sh_bright   <= '0;
            cfg_pending <= 1'b0;
        end else if (cfg_load && (!ctrl_enable || wrap)) begin
            sh_digits   <= cfg_digits;
            sh_dp       <= cfg_dp;
            sh_blank    <= cfg_blank;
            sh_bright   <= cfg_bright;
            cfg_pending <= 1'b0;
        end else if (wrap && cfg_pending) begin
            sh_digits   <= pend_digits;
            sh_dp       <= pend_dp;
            sh_blank    <= pend_blank;
            sh_bright   <= pend_bright;
            cfg_pending <= 1'b0;
        end else if (cfg_load) begin
            pend_digits <= cfg_digits;
            pend_dp     <= cfg_dp;
            pend_blank  <= cfg_blank;
            pend_bright <= cfg_bright;
            cfg_pending <= 1'b1;
        end
    end

    // Registered pin drive; anode, cathodes and dp change together
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            dp         <= ~sh_dp[d];
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller with a 64-cycle slot and
// 2 dead cycles. Every scenario starts on a frame_done cycle, so the
// n-th following negedge shows the outputs for frame position n.
module tb_sseg_scan_controller;

    logic        ACLK;
    logic        ARESETN;
    logic        ctrl_enable;
    logic        cfg_load;
    logic [15:0] cfg_digits;
    logic [3:0]  cfg_dp;
    logic [3:0]  cfg_blank;
    logic [3:0]  cfg_bright;
    logic        cfg_pending;
    logic        frame_done;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_assert;
    int n_fail;

    sseg_scan_controller #(
        .SLOT_BITS  (6),
        .DEAD_CYCLES(2)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .ctrl_enable(ctrl_enable),
        .cfg_load   (cfg_load),
        .cfg_digits (cfg_digits),
        .cfg_dp     (cfg_dp),
        .cfg_blank  (cfg_blank),
        .cfg_bright (cfg_bright),
        .cfg_pending(cfg_pending),
        .frame_done (frame_done),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Hand-entered segment table (active low, g in MSB)
    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: seg_code = 7'h40;  4'h1: seg_code = 7'h79;
            4'h2: seg_code = 7'h24;  4'h3: seg_code = 7'h30;
            4'h4: seg_code = 7'h19;  4'h5: seg_code = 7'h12;
            4'h6: seg_code = 7'h02;  4'h7: seg_code = 7'h78;
            4'h8: seg_code = 7'h00;  4'h9: seg_code = 7'h10;
            4'hA: seg_code = 7'h08;  4'hB: seg_code = 7'h03;
            4'hC: seg_code = 7'h46;  4'hD: seg_code = 7'h21;
            4'hE: seg_code = 7'h06;  default: seg_code = 7'h0E;
        endcase
    endfunction

    // Expected anodes at frame position p (0..255)
    function automatic logic [3:0] an_model(input int p, input logic [3:0] brt, input logic [3:0] blk);
        int c;
        int dg;
        c = p % 64;
        dg = p / 64;
        an_model = 4'hF;
        if (c >= 2 && (c / 4) <= int'(brt) && blk[dg] == 1'b0) an_model[dg] = 1'b0;
    endfunction

    task automatic test_reset();
        ctrl_enable = 1'b1;
        cfg_digits = 16'h1234; cfg_dp = 4'b0001; cfg_blank = 4'h0; cfg_bright = 4'hF; cfg_load = 1'b1;
        @(negedge ACLK);
        cfg_load = 1'b0;
        n_assert++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL reset_pre_pending got %b exp 1", cfg_pending); end
        repeat (2) @(negedge ACLK);
        n_assert++; if (an !== 4'b1110) begin n_fail++; $display("FAIL reset_pre_an got %b exp 1110", an); end
        #2 ARESETN = 1'b0;
        #1;
        n_assert++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an got %b exp 1111", an); end
        n_assert++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h exp 7f", seg); end
        n_assert++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b exp 1", dp); end
        n_assert++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b exp 0", cfg_pending); end
        n_assert++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b exp 0", frame_done); end
        @(negedge ACLK);
        ARESETN = 1'b1;
        // Pending 1234 was discarded: two frames of all-zero digits, bright 0
        for (int t = 0; t < 512; t++) begin
            int p;
            @(negedge ACLK);
            p = t % 256;
            n_assert++; if (an !== an_model(p, 4'h0, 4'h0)) begin n_fail++; $display("FAIL reset_scan_an t=%0d got %b exp %b", t, an, an_model(p, 4'h0, 4'h0)); end
            n_assert++; if (seg !== 7'h40) begin n_fail++; $display("FAIL reset_scan_seg t=%0d got %h exp 40", t, seg); end
            n_assert++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_scan_dp t=%0d got %b exp 1", t, dp); end
            n_assert++; if (frame_done !== (p == 255)) begin n_fail++; $display("FAIL reset_scan_fd t=%0d got %b exp %b", t, frame_done, p == 255); end
            n_assert++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL reset_scan_pending t=%0d got %b exp 0", t, cfg_pending); end
        end
    endtask

    task automatic test_basic_scan();
        logic [15:0] dig;
        logic [3:0]  dpb;
        logic [3:0]  brt;
        cfg_digits = 16'h1234; cfg_dp = 4'b0001; cfg_blank = 4'h0; cfg_bright = 4'hF; cfg_load = 1'b1;
        for (int t = 0; t < 512; t++) begin
            int p;
            int dg;
            @(negedge ACLK);
            cfg_load = 1'b0;
            p = t % 256; dg = p / 64;
            if (t < 256) begin dig = 16'h0000; dpb = 4'b0000; brt = 4'h0; end
            else begin dig = 16'h1234; dpb = 4'b0001; brt = 4'hF; end
            n_assert++; if (an !== an_model(p, brt, 4'h0)) begin n_fail++; $display("FAIL basic_an t=%0d got %b exp %b", t, an, an_model(p, brt, 4'h0)); end
            n_assert++; if (seg !== seg_code(dig[dg*4 +: 4])) begin n_fail++; $display("FAIL basic_seg t=%0d got %h exp %h", t, seg, seg_code(dig[dg*4 +: 4])); end
            n_assert++; if (dp !== ~dpb[dg]) begin n_fail++; $display("FAIL basic_dp t=%0d got %b exp %b", t, dp, ~dpb[dg]); end
            n_assert++; if (frame_done !== (p == 255)) begin n_fail++; $display("FAIL basic_fd t=%0d got %b exp %b", t, frame_done, p == 255); end
            n_assert++; if (cfg_pending !== (t < 255)) begin n_fail++; $display("FAIL basic_pending t=%0d got %b exp %b", t, cfg_pending, t < 255); end
        end
    endtask

    task automatic test_brightness();
        logic [3:0] n_blk [2];
        logic [3:0] n_brt [2];
        int         exp_on [2][4];
        n_blk[0] = 4'b0100; n_brt[0] = 4'h3;
        n_blk[1] = 4'b0000; n_brt[1] = 4'h0;
        exp_on[0] = '{14, 14, 0, 14};
        exp_on[1] = '{2, 2, 2, 2};
        for (int k = 0; k < 2; k++) begin
            int on_cnt [4];
            on_cnt = '{0, 0, 0, 0};
            cfg_digits = 16'h1234; cfg_dp = 4'b0000; cfg_blank = n_blk[k]; cfg_bright = n_brt[k]; cfg_load = 1'b1;
            for (int t = 0; t < 512; t++) begin
                int p;
                @(negedge ACLK);
                cfg_load = 1'b0;
                p = t % 256;
                if (t >= 256) begin
                    for (int i = 0; i < 4; i++) if (an[i] == 1'b0) on_cnt[i]++;
                    n_assert++; if (an !== an_model(p, n_brt[k], n_blk[k])) begin n_fail++; $display("FAIL bright_an k=%0d t=%0d got %b exp %b", k, t, an, an_model(p, n_brt[k], n_blk[k])); end
                end
                n_assert++; if (frame_done !== (p == 255)) begin n_fail++; $display("FAIL bright_fd k=%0d t=%0d got %b exp %b", k, t, frame_done, p == 255); end
            end
            for (int i = 0; i < 4; i++) begin
                n_assert++; if (on_cnt[i] != exp_on[k][i]) begin n_fail++; $display("FAIL bright_on_cycles k=%0d digit=%0d got %0d exp %0d", k, i, on_cnt[i], exp_on[k][i]); end
            end
        end
    endtask

    task automatic test_tear_free();
        logic [15:0] dig;
        logic [3:0]  brt;
        logic        e_pend;
        cfg_digits = 16'h1234; cfg_dp = 4'b0000; cfg_blank = 4'h0; cfg_bright = 4'hF; cfg_load = 1'b1;
        for (int t = 0; t < 768; t++) begin
            int p;
            int f;
            int dg;
            @(negedge ACLK);
            p = t % 256; f = t / 256; dg = p / 64;
            if (t == 0 || (f == 1 && (p == 101 || p == 121))) cfg_load = 1'b0;
            case (f)
                0: begin dig = 16'h1234; brt = 4'h0; e_pend = (p < 255); end
                1: begin dig = 16'h1234; brt = 4'hF; e_pend = (p >= 101 && p < 255); end
                default: begin dig = 16'hBEEF; brt = 4'hF; e_pend = 1'b0; end
            endcase
            n_assert++; if (an !== an_model(p, brt, 4'h0)) begin n_fail++; $display("FAIL tear_an t=%0d got %b exp %b", t, an, an_model(p, brt, 4'h0)); end
            n_assert++; if (seg !== seg_code(dig[dg*4 +: 4])) begin n_fail++; $display("FAIL tear_seg t=%0d got %h exp %h", t, seg, seg_code(dig[dg*4 +: 4])); end
            n_assert++; if (frame_done !== (p == 255)) begin n_fail++; $display("FAIL tear_fd t=%0d got %b exp %b", t, frame_done, p == 255); end
            n_assert++; if (cfg_pending !== e_pend) begin n_fail++; $display("FAIL tear_pending t=%0d got %b exp %b", t, cfg_pending, e_pend); end
            if (f == 1 && p == 100) begin cfg_digits = 16'hAAAA; cfg_load = 1'b1; end
            if (f == 1 && p == 120) begin cfg_digits = 16'hBEEF; cfg_load = 1'b1; end
        end
    endtask

    task automatic test_coincident();
        logic [15:0] dig;
        logic        e_pend;
        cfg_dp = 4'b0000; cfg_blank = 4'h0; cfg_bright = 4'hF;
        for (int t = 0; t < 512; t++) begin
            int p;
            int f;
            int dg;
            @(negedge ACLK);
            p = t % 256; f = t / 256; dg = p / 64;
            if (f == 0 && (p == 51 || p == 255)) cfg_load = 1'b0;
            dig = (f == 0) ? 16'hBEEF : 16'h5555;
            e_pend = (f == 0 && p >= 51 && p <= 254);
            n_assert++; if (an !== an_model(p, 4'hF, 4'h0)) begin n_fail++; $display("FAIL coinc_an t=%0d got %b exp %b", t, an, an_model(p, 4'hF, 4'h0)); end
            n_assert++; if (seg !== seg_code(dig[dg*4 +: 4])) begin n_fail++; $display("FAIL coinc_seg t=%0d got %h exp %h", t, seg, seg_code(dig[dg*4 +: 4])); end
            n_assert++; if (frame_done !== (p == 255)) begin n_fail++; $display("FAIL coinc_fd t=%0d got %b exp %b", t, frame_done, p == 255); end
            n_assert++; if (cfg_pending !== e_pend) begin n_fail++; $display("FAIL coinc_pending t=%0d got %b exp %b", t, cfg_pending, e_pend); end
            if (f == 0 && p == 50) begin cfg_digits = 16'h1111; cfg_load = 1'b1; end
            if (f == 0 && p == 254) begin cfg_digits = 16'h5555; cfg_load = 1'b1; end
        end
    endtask

    task automatic test_disable();
        logic [15:0] dig;
        logic [3:0]  dpb;
        // Part of a 5555 frame, then disable mid-slot of digit 1
        for (int t = 0; t < 100; t++) begin
            @(negedge ACLK);
            n_assert++; if (an !== an_model(t, 4'hF, 4'h0)) begin n_fail++; $display("FAIL dis_pre_an t=%0d got %b exp %b", t, an, an_model(t, 4'hF, 4'h0)); end
            n_assert++; if (seg !== 7'h12) begin n_fail++; $display("FAIL dis_pre_seg t=%0d got %h exp 12", t, seg); end
        end
        ctrl_enable = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic [6:0] e_seg;
            @(negedge ACLK);
            if (i == 11) cfg_load = 1'b0;
            e_seg = (i <= 11) ? 7'h12 : 7'h06;
            n_assert++; if (an !== 4'b1111) begin n_fail++; $display("FAIL dis_an i=%0d got %b exp 1111", i, an); end
            n_assert++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL dis_fd i=%0d got %b exp 0", i, frame_done); end
            n_assert++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL dis_pending i=%0d got %b exp 0", i, cfg_pending); end
            n_assert++; if (seg !== e_seg) begin n_fail++; $display("FAIL dis_seg i=%0d got %h exp %h", i, seg, e_seg); end
            if (i == 10) begin
                cfg_digits = 16'hC0DE; cfg_dp = 4'b1000; cfg_blank = 4'h0; cfg_bright = 4'hF; cfg_load = 1'b1;
            end
        end
        ctrl_enable = 1'b1;
        dig = 16'hC0DE; dpb = 4'b1000;
        for (int t = 0; t < 256; t++) begin
            int dg;
            @(negedge ACLK);
            dg = t / 64;
            n_assert++; if (an !== an_model(t, 4'hF, 4'h0)) begin n_fail++; $display("FAIL reen_an t=%0d got %b exp %b", t, an, an_model(t, 4'hF, 4'h0)); end
            n_assert++; if (seg !== seg_code(dig[dg*4 +: 4])) begin n_fail++; $display("FAIL reen_seg t=%0d got %h exp %h", t, seg, seg_code(dig[dg*4 +: 4])); end
            n_assert++; if (dp !== ~dpb[dg]) begin n_fail++; $display("FAIL reen_dp t=%0d got %b exp %b", t, dp, ~dpb[dg]); end
            n_assert++; if (frame_done !== (t == 255)) begin n_fail++; $display("FAIL reen_fd t=%0d got %b exp %b", t, frame_done, t == 255); end
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        ARESETN = 1'b0;
        ctrl_enable = 1'b0;
        cfg_load = 1'b0;
        cfg_digits = 16'h0000;
        cfg_dp = 4'h0;
        cfg_blank = 4'h0;
        cfg_bright = 4'h0;
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        test_reset();
        test_basic_scan();
        test_brightness();
        test_tear_free();
        test_coincident();
        test_disable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached, got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule
